// File: rtl/mem_wait_if.sv
// Purpose : load/store request bus between the MEM stage and the data memory.
// Latency : none, this is wiring only.
// Backpressure: the slave holds ready low while an access is in flight and
//               the master keeps its request and operands steady until ready.
// Ports   : rd_en, wr_en, address, write_data (master -> slave);
//           read_data, ready (slave -> master).
interface mem_wait_if;
  logic        rd_en;
  logic        wr_en;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        ready;

  modport master (
    output rd_en,
    output wr_en,
    output address,
    output write_data,
    input  read_data,
    input  ready
  );

  modport slave (
    input  rd_en,
    input  wr_en,
    input  address,
    input  write_data,
    output read_data,
    output ready
  );
endinterface

// File: rtl/mem_wait_responder.sv
// Purpose : word-addressed data memory for the MEM stage with a fixed access latency.
// Latency : WAIT_CYCLES cycles per access, from the first request cycle to completion inclusive.
// Backpressure: ready is low while the access is pending; the pipeline freezes on ~ready.
// Ports   : clk, rst (synchronous, active-high);
//           bus (slave side of mem_wait_if): rd_en/wr_en/address/write_data in,
//           read_data/ready out.
module mem_wait_responder #(
  parameter int WAIT_CYCLES = 4,    // 2..15
  parameter int DEPTH       = 64,   // power of two
  parameter int BASE_ADDR   = 1024  // byte address of word 0
) (
  input  logic       clk,
  input  logic       rst,
  mem_wait_if.slave  bus
);

  localparam int          IDX_W   = $clog2(DEPTH);
  localparam logic [3:0]  LAST    = 4'(WAIT_CYCLES - 1);
  localparam logic [31:0] BASE    = 32'(BASE_ADDR);
  localparam logic [29:0] DEPTH_W = 30'(DEPTH);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  state_t      state;
  logic [3:0]  count;
  logic [31:0] lat_addr;
  logic [31:0] lat_data;
  logic        lat_store;

  logic [31:0] mem [DEPTH];

  logic             req;
  logic             at_last;
  logic             done;
  logic [31:0]      offset;
  logic [29:0]      word;
  logic             in_range;
  logic [IDX_W-1:0] idx;
  logic             unused_bits;

  assign req     = bus.rd_en | bus.wr_en;
  assign at_last = (state == BUSY) && (count == LAST);
  // Completion needs the request to still be held; a dropped request aborts.
  assign done    = at_last && req;

  // Address decode works on the latched address so later bus changes are ignored.
  // The subtraction wraps for addresses below the base, which the explicit
  // compare catches; the word compare keeps index aliasing from hitting word 0.
  assign offset      = lat_addr - BASE;
  assign word        = offset[31:2];
  assign in_range    = (lat_addr >= BASE) && (word < DEPTH_W);
  assign idx         = word[IDX_W-1:0];
  assign unused_bits = ^offset[1:0];

  assign bus.ready     = ~req | at_last;
  assign bus.read_data = (done && !lat_store && in_range) ? mem[idx] : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      count     <= 4'd0;
      lat_addr  <= 32'd0;
      lat_data  <= 32'd0;
      lat_store <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            lat_addr  <= bus.address;
            lat_data  <= bus.write_data;
            // Both enables high is treated as a store.
            lat_store <= bus.wr_en;
            state     <= BUSY;
            count     <= 4'd1;
          end
        end
        BUSY: begin
          if (!req || count == LAST) begin
            state <= IDLE;
            count <= 4'd0;
          end else begin
            count <= count + 4'd1;
          end
        end
        default: begin
          state <= IDLE;
          count <= 4'd0;
        end
      endcase
    end
  end

  // Array is deliberately not reset; a reset in the completion cycle suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && done && lat_store && in_range) begin
      mem[idx] <= lat_data;
    end
  end

endmodule

// File: tb/tb_mem_wait_responder.sv
module tb_mem_wait_responder;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mem_wait_if bus ();

  mem_wait_responder #(
    .WAIT_CYCLES(4),
    .DEPTH(64),
    .BASE_ADDR(1024)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_bus(input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] data);
    bus.rd_en      = rd;
    bus.wr_en      = wr;
    bus.address    = addr;
    bus.write_data = data;
  endtask

  // Drives one access starting right after a rising edge and holds it until
  // ready is seen. Returns cycle count, ready-low count, read_data sampled in
  // the completion cycle and count of non-zero read_data in other cycles.
  // Optionally swaps address/data from the second cycle on.
  task automatic run_access(input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] data,
                            input logic chg,
                            input logic [31:0] alt_addr, input logic [31:0] alt_data,
                            output int cyc, output int low,
                            output logic [31:0] rdat, output int nz);
    logic fin;
    cyc  = 0;
    low  = 0;
    nz   = 0;
    rdat = 32'hFFFF_FFFF;
    fin  = 1'b0;
    while (!fin && cyc < 20) begin
      #1;
      if (cyc == 0) set_bus(rd, wr, addr, data);
      if (cyc == 1 && chg) begin
        bus.address    = alt_addr;
        bus.write_data = alt_data;
      end
      #3;
      if (bus.ready) begin
        rdat = bus.read_data;
        fin  = 1'b1;
      end else begin
        low++;
        if (bus.read_data !== 32'd0) nz++;
      end
      cyc++;
      @(posedge clk);
    end
  endtask

  task automatic idle_cycle();
    #1 set_bus(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_bus(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    @(posedge clk);
    #4;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got=%b want=1", bus.ready);
    end
    checks++;
    if (bus.read_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_rdata got=%h want=0", bus.read_data);
    end
    // ready follows ~req while held in reset.
    bus.rd_en = 1'b1;
    #1;
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready_req got=%b want=0", bus.ready);
    end
    @(posedge clk);
    #1 bus.rd_en = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
  endtask

  task automatic test_store_load();
    int cyc, low, nz;
    logic [31:0] rdat;
    run_access(1'b0, 1'b1, 32'd1032, 32'hDEADBEEF, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (cyc !== 4 || low !== 3) begin
      errors++;
      $display("FAIL st_latency cycles=%0d low=%0d want 4/3", cyc, low);
    end
    checks++;
    if (rdat !== 32'd0 || nz !== 0) begin
      errors++;
      $display("FAIL st_rdata got=%h nz=%0d want 0", rdat, nz);
    end
    run_access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (cyc !== 4 || low !== 3) begin
      errors++;
      $display("FAIL ld_latency cycles=%0d low=%0d want 4/3", cyc, low);
    end
    checks++;
    if (rdat !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL ld_rdata got=%h want=deadbeef", rdat);
    end
    checks++;
    if (nz !== 0) begin
      errors++;
      $display("FAIL ld_rdata_early nonzero=%0d want 0", nz);
    end
    idle_cycle();
  endtask

  task automatic test_back_to_back();
    int cyc, low, nz;
    logic [31:0] rdat;
    run_access(1'b0, 1'b1, 32'd1028, 32'h11, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (cyc !== 4 || low !== 3) begin
      errors++;
      $display("FAIL b2b_st1 cycles=%0d low=%0d want 4/3", cyc, low);
    end
    run_access(1'b0, 1'b1, 32'd1032, 32'h22, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (cyc !== 4 || low !== 3) begin
      errors++;
      $display("FAIL b2b_st2 cycles=%0d low=%0d want 4/3", cyc, low);
    end
    run_access(1'b1, 1'b0, 32'd1028, 32'd0, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (rdat !== 32'h11 || cyc !== 4) begin
      errors++;
      $display("FAIL b2b_ld1 got=%h cycles=%0d want 11/4", rdat, cyc);
    end
    run_access(1'b1, 1'b0, 32'd1032, 32'd0, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (rdat !== 32'h22 || cyc !== 4) begin
      errors++;
      $display("FAIL b2b_ld2 got=%h cycles=%0d want 22/4", rdat, cyc);
    end
    idle_cycle();
  endtask

  task automatic test_out_of_range();
    int cyc, low, nz;
    logic [31:0] rdat;
    run_access(1'b0, 1'b1, 32'd1024, 32'hA5A5A5A5, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    run_access(1'b0, 1'b1, 32'd1020, 32'h55, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (cyc !== 4 || low !== 3) begin
      errors++;
      $display("FAIL oor_st_low cycles=%0d low=%0d want 4/3", cyc, low);
    end
    run_access(1'b0, 1'b1, 32'd1280, 32'h55, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (cyc !== 4 || low !== 3) begin
      errors++;
      $display("FAIL oor_st_high cycles=%0d low=%0d want 4/3", cyc, low);
    end
    run_access(1'b1, 1'b0, 32'd1020, 32'd0, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (rdat !== 32'd0 || cyc !== 4) begin
      errors++;
      $display("FAIL oor_ld_low got=%h cycles=%0d want 0/4", rdat, cyc);
    end
    run_access(1'b1, 1'b0, 32'd1280, 32'd0, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (rdat !== 32'd0 || cyc !== 4) begin
      errors++;
      $display("FAIL oor_ld_high got=%h cycles=%0d want 0/4", rdat, cyc);
    end
    run_access(1'b1, 1'b0, 32'd1024, 32'd0, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (rdat !== 32'hA5A5A5A5) begin
      errors++;
      $display("FAIL oor_neighbour got=%h want=a5a5a5a5", rdat);
    end
    idle_cycle();
  endtask

  task automatic test_abort_reset();
    int cyc, low, nz;
    logic [31:0] rdat;
    run_access(1'b0, 1'b1, 32'd1036, 32'h1234, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    // Store dropped after two cycles.
    #1 set_bus(1'b0, 1'b1, 32'd1036, 32'h9999);
    @(posedge clk);
    @(posedge clk);
    #1 set_bus(1'b0, 1'b0, 32'd0, 32'd0);
    #3;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL abort_ready got=%b want=1", bus.ready);
    end
    @(posedge clk);
    run_access(1'b1, 1'b0, 32'd1036, 32'd0, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (rdat !== 32'h1234 || cyc !== 4) begin
      errors++;
      $display("FAIL abort_nowrite got=%h cycles=%0d want 1234/4", rdat, cyc);
    end
    idle_cycle();
    // Store with reset asserted in its completion cycle.
    #1 set_bus(1'b0, 1'b1, 32'd1036, 32'hBBBB);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #3;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_completion_ready got=%b want=1", bus.ready);
    end
    @(posedge clk);
    #1 rst = 1'b0;
    set_bus(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    run_access(1'b1, 1'b0, 32'd1036, 32'd0, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (rdat !== 32'h1234 || cyc !== 4 || low !== 3) begin
      errors++;
      $display("FAIL rst_nowrite got=%h cycles=%0d low=%0d want 1234/4/3", rdat, cyc, low);
    end
    idle_cycle();
  endtask

  task automatic test_both_enables();
    int cyc, low, nz;
    logic [31:0] rdat;
    run_access(1'b1, 1'b1, 32'd1040, 32'h77, 1'b1, 32'd1044, 32'h88, cyc, low, rdat, nz);
    checks++;
    if (cyc !== 4 || low !== 3) begin
      errors++;
      $display("FAIL both_latency cycles=%0d low=%0d want 4/3", cyc, low);
    end
    checks++;
    if (rdat !== 32'd0 || nz !== 0) begin
      errors++;
      $display("FAIL both_rdata got=%h nz=%0d want 0", rdat, nz);
    end
    run_access(1'b1, 1'b0, 32'd1040, 32'd0, 1'b0, 32'd0, 32'd0, cyc, low, rdat, nz);
    checks++;
    if (rdat !== 32'h77) begin
      errors++;
      $display("FAIL both_written got=%h want=77", rdat);
    end
    idle_cycle();
  endtask

  task automatic test_idle();
    #1 set_bus(1'b0, 1'b0, 32'd1032, 32'd0);
    for (int i = 0; i < 10; i++) begin
      #3;
      checks++;
      if (bus.ready !== 1'b1 || bus.read_data !== 32'd0) begin
        errors++;
        $display("FAIL idle_cycle%0d ready=%b rdata=%h want 1/0", i, bus.ready, bus.read_data);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    set_bus(1'b0, 1'b0, 32'd0, 32'd0);
    @(posedge clk);
    test_reset();
    test_store_load();
    test_back_to_back();
    test_out_of_range();
    test_abort_reset();
    test_both_enables();
    test_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_wait_responder.md
# mem_wait_responder

Data-memory responder for the ARM pipeline's MEM stage. It accepts single-word load/store requests, models a fixed multi-cycle access latency and deasserts `ready` so the top level can hold the pipeline until the access completes (`freeze = ~ready`). It owns the word-addressed data array behind the pipeline's data address window.

## Interface
- `WAIT_CYCLES`, 4: total cycles per access, counted from the first cycle of the request to the completion cycle inclusive; legal range 2..15.
- `DEPTH`, 64: number of 32-bit words in the array; a power of two.
- `BASE_ADDR`, 1024: byte address of word 0.
- `clk` input 1: the block's only clock.
- `rst` input 1: reset; synchronous, active-high.
- `rd_en` input 1: load request, held by the MEM stage until `ready`.
- `wr_en` input 1: store request, held until `ready`.
- `address` input 32: byte address of the access.
- `write_data` input 32: store data.
- `read_data` output 32: load result; valid only in the completion cycle of a load.
- `ready` output 1: high means no access is pending or the access completes this cycle.

## Operation
- Request: `req = rd_en | wr_en`. If both are high, the access is a store and `read_data` stays 0.
- States:
  - IDLE, counter 0.
  - BUSY, counter 1..WAIT_CYCLES-1.
- IDLE with `req`:
  - Latch `address`, `write_data` and the kind (load or store).
  - Go to BUSY with counter 1.
  - `ready` = 0 in this cycle.
- BUSY with `req` and counter < WAIT_CYCLES-1: counter increments, `ready` = 0.
- BUSY with `req` and counter = WAIT_CYCLES-1 (completion cycle):
  - `ready` = 1.
  - A load drives `read_data` from the array.
  - A store writes the array at the clock edge ending this cycle.
  - Next state is IDLE.
- Request dropped while BUSY: the access aborts, no write happens and the next state is IDLE.
- `address` and `write_data` changes after acceptance are ignored; the latched values are used.
- Index is `(latched_address - BASE_ADDR) >> 2`. Byte offset bits [1:0] are ignored.
- Out of range (address < BASE_ADDR or index >= DEPTH):
  - The access still takes the full WAIT_CYCLES.
  - A store is discarded.
  - A load returns 0.
- `ready` is combinational: `ready = ~req | (BUSY & counter == WAIT_CYCLES-1)`. With no request `ready` is 1.
- `read_data` is 0 in every cycle except a load's completion cycle.
- Back-to-back accesses: if `req` is high in the cycle after completion, it is a new request and is accepted from IDLE. There is no dead cycle beyond IDLE acceptance.

## Timing
- Reset (`rst` high at a clock edge):
  - Next state is IDLE, counter 0, latched address/data/kind cleared to 0.
  - Outputs after reset: `read_data` = 0; `ready` = `~req`.
  - Array contents are not cleared.
- Reset during BUSY: the pending access is dropped and no write happens, even if that cycle was the completion cycle.
- Latency: a request first seen in cycle t completes in cycle t+WAIT_CYCLES-1. `ready` is low for exactly WAIT_CYCLES-1 cycles.
- Stored data is visible to a load accepted in the cycle after the store's completion or later.

## Test plan
- Store then load, WAIT_CYCLES=4: hold `wr_en`, `address`=1024+8, `write_data`=0xDEADBEEF, then hold `rd_en` at the same address. Required response:
  - `ready` low for 3 cycles on each access.
  - `read_data` = 0xDEADBEEF only in the load's 4th cycle, 0 otherwise.
- Back-to-back stores: 0x11 to 1028, then 0x22 to 1032 with no idle gap. Required response:
  - Each store completes 4 cycles after it starts.
  - Loads then return 0x11 and 0x22.
- Out of range: store 0x55 to 1020 and to 1024+4*64, then load both. Required response:
  - Full latency on every access.
  - Both loads return 0.
  - The neighbouring word at 1024 is unchanged.
- Abort and reset: drop `wr_en` after 2 cycles, and separately assert `rst` in the completion cycle. Required response:
  - Neither store writes the array.
  - State returns to IDLE.
  - The next request takes the full 4 cycles.
- Both enables plus operand change: `rd_en` and `wr_en` both high with 0x77 at 1040, and `address` altered after the first cycle. Required response:
  - 0x77 is written to 1040.
  - `read_data` stays 0 throughout.
- Idle: no request for 10 cycles. Required response: `ready` = 1 and `read_data` = 0 on every cycle.
